// File: rtl/axi_drain_gate_pkg.sv
// AXI channel structs, drain-gate state enum and response codes shared by
// axi_drain_gate, its counters and the bench.
package axi_drain_gate_pkg;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        DRAIN   = 2'd1,
        ISOLATE = 2'd2
    } drain_gate_state_e;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [5:0]       atop;
    } aw_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
    } ar_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

endpackage

// File: rtl/axi_drain_gate_cnt.sv
// Outstanding-transaction counter of the drain gate; inc_i may carry two
// increments in one cycle (an AR plus an ATOP with read response).
module axi_drain_gate_cnt #(
    parameter int unsigned MaxTrans = 8,
    localparam int unsigned CntW = $clog2(MaxTrans + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            empty_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else begin
            cnt_o <= cnt_o + CntW'(inc_i) - CntW'(dec_i);
        end
    end

    assign full_o  = 32'(cnt_o) >= MaxTrans;
    assign empty_o = cnt_o == '0;

endmodule

// File: rtl/axi_drain_gate.sv
// AXI4+ATOP drain gate: blocks new AW/AR on isolate_i, drains, then flags
// isolated_o. Define AXI_DRAIN_GATE_TERMINATE_EN to answer with SLVERR in ISOLATE.
module axi_drain_gate
    import axi_drain_gate_pkg::*;
#(
    parameter int unsigned MaxTrans = 8,
    parameter type req_t  = axi_req_t,
    parameter type resp_t = axi_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i,
    input  logic  isolate_i,
    output logic  isolated_o
);

    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    drain_gate_state_e state_q, state_d;
    logic aw_hold_q, ar_hold_q;
    logic [CntW-1:0] aw_pend, w_open, ar_pend;
    logic aw_full, ar_full, w_full, aw_empty, ar_empty, w_empty;
    logic atop_r, aw_room, ar_room, aw_ok, ar_ok, w_ok;
    logic aw_fwd, ar_fwd, w_fwd;
    logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
    logic [1:0] ar_inc;
    logic drained, err_idle;
    logic unused_flags;

    assign unused_flags = ^{aw_empty, ar_empty, w_full};

    assign atop_r    = slv_req_i.aw.atop[5];
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready
                     & mst_resp_i.r.last;

    // A completing response frees its slot in the same cycle.
    assign aw_room = ~aw_full | b_hs;
    assign ar_room = ~ar_full | r_last_hs;

    assign aw_ok = aw_hold_q
                 | (state_q == NORMAL & aw_room & (~atop_r | ar_room));
    assign ar_ok = ar_hold_q | (state_q == NORMAL & ar_room);
    assign w_ok  = ~w_empty;

    assign aw_fwd = slv_req_i.aw_valid & aw_ok;
    assign ar_fwd = slv_req_i.ar_valid & ar_ok;
    assign w_fwd  = slv_req_i.w_valid & w_ok;

    assign aw_hs     = aw_fwd & mst_resp_i.aw_ready;
    assign ar_hs     = ar_fwd & mst_resp_i.ar_ready;
    assign w_last_hs = w_fwd & mst_resp_i.w_ready & slv_req_i.w.last;
    assign ar_inc    = {1'b0, ar_hs} + {1'b0, aw_hs & atop_r};

    axi_drain_gate_cnt #(.MaxTrans(MaxTrans)) i_aw_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  ({1'b0, aw_hs}),
        .dec_i  (b_hs),
        .cnt_o  (aw_pend),
        .full_o (aw_full),
        .empty_o(aw_empty)
    );

    axi_drain_gate_cnt #(.MaxTrans(MaxTrans)) i_w_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  ({1'b0, aw_hs}),
        .dec_i  (w_last_hs),
        .cnt_o  (w_open),
        .full_o (w_full),
        .empty_o(w_empty)
    );

    axi_drain_gate_cnt #(.MaxTrans(MaxTrans)) i_ar_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ar_inc),
        .dec_i  (r_last_hs),
        .cnt_o  (ar_pend),
        .full_o (ar_full),
        .empty_o(ar_empty)
    );

    // Judged on next-cycle counts so isolation follows the last response.
    assign drained = (aw_pend + CntW'(aw_hs) == CntW'(b_hs))
                   & (w_open + CntW'(aw_hs) == CntW'(w_last_hs))
                   & (ar_pend + CntW'(ar_inc) == CntW'(r_last_hs))
                   & ~(aw_fwd & ~mst_resp_i.aw_ready)
                   & ~(ar_fwd & ~mst_resp_i.ar_ready);

`ifdef AXI_DRAIN_GATE_TERMINATE_EN
    logic err_en, err_w_q, err_b_q, err_r_q;
    logic [IdW-1:0] err_bid_q, err_rid_q;
    logic [7:0] err_beats_q;

    assign err_en   = (state_q == ISOLATE) & isolate_i;
    assign err_idle = ~err_w_q & ~err_b_q & ~err_r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_w_q     <= 1'b0;
            err_b_q     <= 1'b0;
            err_r_q     <= 1'b0;
            err_bid_q   <= '0;
            err_rid_q   <= '0;
            err_beats_q <= '0;
        end else begin
            if (err_en & slv_req_i.aw_valid & ~err_w_q & ~err_b_q) begin
                err_w_q   <= 1'b1;
                err_bid_q <= slv_req_i.aw.id;
            end
            if (err_w_q & slv_req_i.w_valid & slv_req_i.w.last) begin
                err_w_q <= 1'b0;
                err_b_q <= 1'b1;
            end
            if (err_b_q & slv_req_i.b_ready) begin
                err_b_q <= 1'b0;
            end
            if (err_en & slv_req_i.ar_valid & ~err_r_q) begin
                err_r_q     <= 1'b1;
                err_rid_q   <= slv_req_i.ar.id;
                err_beats_q <= slv_req_i.ar.len;
            end else if (err_r_q & slv_req_i.r_ready) begin
                if (err_beats_q == '0) err_r_q <= 1'b0;
                else err_beats_q <= err_beats_q - 8'd1;
            end
        end
    end
`else
    assign err_idle = 1'b1;
`endif

    always_comb begin
        mst_req_o = slv_req_i;
        mst_req_o.aw_valid = aw_fwd;
        mst_req_o.w_valid  = w_fwd;
        mst_req_o.ar_valid = ar_fwd;
        slv_resp_o = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_ok;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
`ifdef AXI_DRAIN_GATE_TERMINATE_EN
        if (state_q == ISOLATE) begin
            slv_resp_o.aw_ready = err_en & ~err_w_q & ~err_b_q;
            slv_resp_o.w_ready  = err_w_q;
            slv_resp_o.ar_ready = err_en & ~err_r_q;
            slv_resp_o.b        = '0;
            slv_resp_o.b.id     = err_bid_q;
            slv_resp_o.b.resp   = RESP_SLVERR;
            slv_resp_o.b_valid  = err_b_q;
            slv_resp_o.r        = '0;
            slv_resp_o.r.id     = err_rid_q;
            slv_resp_o.r.resp   = RESP_SLVERR;
            slv_resp_o.r.last   = err_beats_q == '0;
            slv_resp_o.r_valid  = err_r_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL:  if (isolate_i) state_d = DRAIN;
            DRAIN: begin
                if (!isolate_i) state_d = NORMAL;
                else if (drained) state_d = ISOLATE;
            end
            ISOLATE: if (!isolate_i && err_idle) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= NORMAL;
            aw_hold_q  <= 1'b0;
            ar_hold_q  <= 1'b0;
            isolated_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_hold_q  <= aw_fwd & ~mst_resp_i.aw_ready;
            ar_hold_q  <= ar_fwd & ~mst_resp_i.ar_ready;
            isolated_o <= state_d == ISOLATE;
        end
    end

endmodule

// File: tb/tb_axi_drain_gate.sv
// Directed bench for axi_drain_gate (MaxTrans=2) with a transaction-count
// model checked every cycle plus hand-computed point checks.
module tb_axi_drain_gate;
    import axi_drain_gate_pkg::*;

    localparam int MT = 2;

    logic      clk = 1'b0;
    logic      rst_n;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    logic      isolate, isolated;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_drain_gate #(
        .MaxTrans(MT),
        .req_t   (axi_req_t),
        .resp_t  (axi_resp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp),
        .isolate_i (isolate),
        .isolated_o(isolated)
    );

    task automatic chkv(input string name, input logic [159:0] act,
                        input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chkv(name, 160'(act), 160'(exp));
    endtask

    // Model: outstanding counts and the isolation mode (0 run, 1 drain, 2 isolated)
    int awp = 0, wop = 0, arp = 0, mode = 0;
    bit aws = 0, ars = 0;

    task automatic model_step();
        axi_req_t er;
        axi_resp_t es;
        bit b_hs, rl_hs, aw_go, ar_go, w_go, atop_r, aw_hs, ar_hs, wl_hs;
        if (!rst_n) begin
            awp = 0; wop = 0; arp = 0; mode = 0; aws = 0; ars = 0;
        end
        b_hs   = mst_resp.b_valid && slv_req.b_ready;
        rl_hs  = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
        atop_r = slv_req.aw.atop[5];
        aw_go  = aws || (mode == 0 && (awp < MT || b_hs)
                 && (!atop_r || arp < MT || rl_hs));
        ar_go  = ars || (mode == 0 && (arp < MT || rl_hs));
        w_go   = wop > 0;
        er = slv_req;
        er.aw_valid = slv_req.aw_valid && aw_go;
        er.w_valid  = slv_req.w_valid && w_go;
        er.ar_valid = slv_req.ar_valid && ar_go;
        es = mst_resp;
        es.aw_ready = mst_resp.aw_ready && aw_go;
        es.w_ready  = mst_resp.w_ready && w_go;
        es.ar_ready = mst_resp.ar_ready && ar_go;
        chkv("mst_req", 160'(mst_req), 160'(er));
        chkv("slv_resp", 160'(slv_resp), 160'(es));
        chk1("isolated", isolated, mode == 2);
        if (rst_n) begin
            aw_hs = er.aw_valid && mst_resp.aw_ready;
            ar_hs = er.ar_valid && mst_resp.ar_ready;
            wl_hs = er.w_valid && mst_resp.w_ready && slv_req.w.last;
            awp += int'(aw_hs) - int'(b_hs);
            wop += int'(aw_hs) - int'(wl_hs);
            arp += int'(ar_hs) + int'(aw_hs && atop_r) - int'(rl_hs);
            aws = er.aw_valid && !mst_resp.aw_ready;
            ars = er.ar_valid && !mst_resp.ar_ready;
            case (mode)
                0: if (isolate) mode = 1;
                1: begin
                    if (!isolate) mode = 0;
                    else if (awp == 0 && wop == 0 && arp == 0 && !aws && !ars)
                        mode = 2;
                end
                default: if (!isolate) mode = 0;
            endcase
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        slv_req  = '0;
        mst_resp = '0;
    endtask

    task automatic release_iso();
        nxt(); clr(); isolate = 1'b0;
        nxt();
        @(negedge clk);
        chk1("release_iso", isolated, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        isolate = 1'b0;
        clr();
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid  = 1'b1;
        @(negedge clk);
        chk1("rst_isolated", isolated, 1'b0);
        chk1("rst_w_gated", mst_req.w_valid, 1'b0);
        chk1("rst_aw_fwd", mst_req.aw_valid, 1'b1);
        nxt(); rst_n = 1'b1; clr();

        // pass-through write burst
        nxt();
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd3;
        slv_req.aw.len = 8'd3; slv_req.aw.addr = 32'h1000;
        mst_resp.aw_ready = 1'b1;
        @(negedge clk);
        chk1("pt_aw_valid", mst_req.aw_valid, 1'b1);
        chkv("pt_aw_id", 160'(mst_req.aw.id), 160'(3));
        chk1("pt_aw_ready", slv_resp.aw_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            nxt(); clr();
            slv_req.w_valid = 1'b1;
            slv_req.w.data = 32'(32'hA0 + i);
            slv_req.w.last = (i == 3);
            mst_resp.w_ready = 1'b1;
            @(negedge clk);
            chk1("pt_w_valid", mst_req.w_valid, 1'b1);
            chk1("pt_w_ready", slv_resp.w_ready, 1'b1);
        end
        nxt(); clr(); slv_req.w_valid = 1'b1;
        @(negedge clk);
        chk1("pt_w_closed", mst_req.w_valid, 1'b0);
        nxt(); clr();
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd3; slv_req.b_ready = 1'b1;
        @(negedge clk);
        chk1("pt_b_valid", slv_resp.b_valid, 1'b1);
        chkv("pt_b_id", 160'(slv_resp.b.id), 160'(3));
        nxt(); clr();
        @(negedge clk);
        chk1("pt_isolated", isolated, 1'b0);

        // drain two outstanding reads
        nxt(); clr();
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd1; mst_resp.ar_ready = 1'b1;
        nxt(); slv_req.ar.id = 4'd2;
        for (int c = 0; c <= 11; c++) begin
            nxt(); clr();
            if (c == 0) isolate = 1'b1;
            if (c >= 2 && c <= 10) begin
                slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd5;
                mst_resp.ar_ready = 1'b1;
            end
            if (c == 5 || c == 9) begin
                mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
                mst_resp.r.id = (c == 5) ? 4'd1 : 4'd2;
                slv_req.r_ready = 1'b1;
            end
            @(negedge clk);
            if (c >= 2 && c <= 10) begin
                chk1("dr_ar_valid", mst_req.ar_valid, 1'b0);
                chk1("dr_ar_ready", slv_resp.ar_ready, 1'b0);
            end
            if (c == 5) chk1("dr_r_fwd", slv_resp.r_valid, 1'b1);
            if (c == 9) chk1("dr_not_yet", isolated, 1'b0);
            if (c == 10) chk1("dr_isolated", isolated, 1'b1);
        end
        release_iso();

        // AW held open across the isolate request
        for (int c = 0; c <= 8; c++) begin
            nxt(); clr();
            if (c == 0) isolate = 1'b1;
            if (c <= 3) begin
                slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd7;
                mst_resp.aw_ready = (c == 3);
            end
            if (c == 5) begin
                slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
                mst_resp.w_ready = 1'b1;
            end
            if (c == 7) begin
                mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
            end
            @(negedge clk);
            if (c <= 3) chk1("hold_aw_valid", mst_req.aw_valid, 1'b1);
            if (c == 3) chk1("hold_aw_ready", slv_resp.aw_ready, 1'b1);
            if (c == 5) chk1("hold_w_fwd", mst_req.w_valid, 1'b1);
            if (c == 7) chk1("hold_not_yet", isolated, 1'b0);
            if (c == 8) chk1("hold_isolated", isolated, 1'b1);
        end
        release_iso();

        // AR limit at MaxTrans=2
        for (int c = 0; c <= 8; c++) begin
            nxt(); clr();
            if (c <= 5) begin
                slv_req.ar_valid = 1'b1;
                slv_req.ar.id = (c < 2) ? 4'(c + 1) : (c <= 4 ? 4'd3 : 4'd4);
                mst_resp.ar_ready = 1'b1;
            end
            if (c == 4 || c == 6 || c == 7) begin
                mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
                slv_req.r_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 2 || c == 3) begin
                chk1("lim_ar_stall", mst_req.ar_valid, 1'b0);
                chk1("lim_ar_ready", slv_resp.ar_ready, 1'b0);
            end
            if (c == 4) begin
                chk1("lim_ar_go", mst_req.ar_valid, 1'b1);
                chk1("lim_ar_hs", slv_resp.ar_ready, 1'b1);
            end
            if (c == 5) chk1("lim_still_full", mst_req.ar_valid, 1'b0);
        end

        // ATOP with read response
        for (int c = 0; c <= 6; c++) begin
            nxt(); clr();
            if (c == 0) begin
                slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd2;
                slv_req.aw.atop = 6'b100000; mst_resp.aw_ready = 1'b1;
            end
            if (c == 1) begin
                isolate = 1'b1;
                slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
                mst_resp.w_ready = 1'b1;
            end
            if (c == 2) begin
                mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
            end
            if (c == 4) begin
                mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
                slv_req.r_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 0) chk1("atop_aw_fwd", mst_req.aw_valid, 1'b1);
            if (c == 3 || c == 4) chk1("atop_wait_r", isolated, 1'b0);
            if (c == 5) chk1("atop_isolated", isolated, 1'b1);
        end
        release_iso();

        // reset while draining
        for (int c = 0; c <= 6; c++) begin
            nxt(); clr();
            if (c == 0) begin
                slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd9;
                mst_resp.ar_ready = 1'b1;
            end
            if (c == 1) isolate = 1'b1;
            if (c == 2 || c == 3) slv_req.ar_valid = 1'b1;
            if (c == 3) begin
                rst_n = 1'b0;
                slv_req.w_valid = 1'b1;
            end
            if (c == 4) rst_n = 1'b1;
            @(negedge clk);
            if (c == 2) begin
                chk1("rd_drain", isolated, 1'b0);
                chk1("rd_ar_block", mst_req.ar_valid, 1'b0);
            end
            if (c == 3) begin
                chk1("rd_iso_low", isolated, 1'b0);
                chk1("rd_ar_normal", mst_req.ar_valid, 1'b1);
                chk1("rd_w_gated", mst_req.w_valid, 1'b0);
            end
            if (c == 6) chk1("rd_cnt_clear", isolated, 1'b1);
        end
        release_iso();

        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
